fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction fetch stage and IF/ID pipeline register that sits directly upstream of the decode/control logic. It holds the PC and issues single-outstanding requests to instruction memory, which may have variable latency. It captures the returned instruction into the IF/ID register and supplies its opcode to the control unit. It consumes the control unit's 2-bit PCSrc and redirects on branches and jumps, flushing wrong-path fetches, and buffers a response that arrives while decode is stalled.

Parameters:
XLEN, 32, datapath/address width
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, instruction driven when IF/ID is invalid (addi x0,x0,0)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  reset; asynchronous assert, active-low
pc_src  in  2  from control unit: 0=PC+4, 1=branch/jal target, 2=jalr target, 3=reserved (treated as 0)
branch_target  in  XLEN  if_id_pc+imm for SB/UJ
jalr_target  in  XLEN  rs1+imm for jalr
stall  in  1  decode cannot accept; hold IF/ID
imem_req  out  1  fetch request valid
imem_addr  out  XLEN  fetch address (= pc register)
imem_rdata  in  32  instruction word
imem_valid  in  1  response valid; may assert in the request cycle (0-latency) or any later cycle
if_id_valid  out  1  IF/ID holds a real instruction
if_id_instr  out  32  registered instruction; NOP_INSTR when if_id_valid=0
if_id_pc  out  XLEN  address of if_id_instr
if_id_pc_plus4  out  XLEN  if_id_pc+4, link value for jal/jalr
opcode  out  7  if_id_instr[6:0], to control unit

Behaviour:
- Reset (rst_n=0, async): pc=RESET_PC; state=WAIT; if_id_valid=0; if_id_instr=NOP_INSTR; if_id_pc=0; if_id_pc_plus4=4; skid empty. imem_req is forced to 0 while rst_n=0.
- The control unit never sees opcode 0; it sees 7'h13 when the stage is invalid.
- redirect = if_id_valid & (pc_src==1 | pc_src==2).
- Redirect target:
  - pc_src=1 selects branch_target.
  - pc_src=2 selects jalr_target with bit0 cleared.
- PC arithmetic is modulo 2^XLEN; 32'hFFFF_FFFC+4 wraps to 0.
- States:
  - WAIT: imem_req=1, imem_addr=pc.
  - DRAIN: imem_req=0; the outstanding response will be discarded.
  - HELD: imem_req=0; skid holds an accepted response plus its pc.
- Priority per cycle: reset > redirect > stall > normal.
- WAIT, redirect:
  - pc<=target; if_id_valid<=0.
  - If imem_valid=1 this cycle: discard the response, stay WAIT.
  - Else: go DRAIN.
- WAIT, no redirect, imem_valid=1, stall=0: IF/ID<=(rdata,pc,pc+4); if_id_valid<=1; pc<=pc+4; stay WAIT. With a 0-latency memory this gives 1 instruction/cycle.
- WAIT, no redirect, imem_valid=1, stall=1: skid<=(rdata,pc); pc<=pc+4; go HELD. IF/ID unchanged.
- WAIT, imem_valid=0, no redirect: IF/ID holds; if_id_valid unchanged if stall=1, else if_id_valid<=0 (bubble).
- DRAIN:
  - On imem_valid: drop the data, go WAIT.
  - A further redirect in DRAIN only updates pc.
  - if_id_valid stays 0.
- HELD:
  - stall=0: IF/ID<=skid, if_id_valid<=1, go WAIT.
  - redirect: discard skid, pc<=target, if_id_valid<=0, go WAIT.
- Redirect overrides stall (flush wins).
- Exactly one request is outstanding at any time. imem_addr is stable while imem_req=1 and not yet responded.
- Reset mid-DRAIN/HELD returns to the reset values immediately; a late imem_valid after reset is treated as a response to the RESET_PC request (the memory must also be reset).

Test Plan:
- Reset release, 0-latency imem returning 0x00500093 at addr 0 -> cycle 1 if_id_valid=1, if_id_instr=0x00500093, if_id_pc=0, if_id_pc_plus4=4; imem_addr=4.
- Sequential fetch, 2-cycle latency -> imem_addr holds 0 for 2 cycles then steps 4,8,12; if_id_valid pulses once per response with bubbles between.
- Branch at pc=8 decoded with pc_src=1, branch_target=0x40 -> next imem_addr=0x40; if_id_valid=0 for one cycle; the wrong-path word at 0xC never appears in IF/ID.
- jalr with pc_src=2, jalr_target=0x105 -> imem_addr=0x104.
- stall=1 for 3 cycles while a response for 0x10 arrives -> imem_req=0 in HELD; IF/ID unchanged; one cycle after stall=0, if_id_instr equals the 0x10 word and if_id_pc=0x10.
- Redirect with a 3-cycle-latency request in flight, then rst_n pulsed low mid-DRAIN -> the stale response is dropped; on reset, pc=RESET_PC, if_id_valid=0, opcode=7'h13 asynchronously.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel between the fetch stage
// (master) and the instruction memory (slave). One request is outstanding
// at a time; the response may arrive in the request cycle or any later one.
interface fetch_stage_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            imem_valid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_valid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_valid
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register. Holds the PC, issues
// single-outstanding requests to a variable-latency instruction memory,
// redirects on branch/jal/jalr from the control unit, discards wrong-path
// responses and parks a response in a skid buffer while decode is stalled.
module fetch_stage #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        pc_src,
    input  logic [XLEN-1:0]   branch_target,
    input  logic [XLEN-1:0]   jalr_target,
    input  logic              stall,
    fetch_stage_if.master     imem,
    output logic              if_id_valid,
    output logic [31:0]       if_id_instr,
    output logic [XLEN-1:0]   if_id_pc,
    output logic [XLEN-1:0]   if_id_pc_plus4,
    output logic [6:0]        opcode
);

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HELD  = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
    localparam logic [XLEN-1:0] PC_RESET = XLEN'(RESET_PC);

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            if_id_valid_q, if_id_valid_d;
    logic [31:0]     if_id_instr_q, if_id_instr_d;
    logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
    logic [XLEN-1:0] if_id_pc_plus4_q, if_id_pc_plus4_d;
    logic [31:0]     skid_instr_q, skid_instr_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;

    logic            redirect;
    logic [XLEN-1:0] redirect_target;
    logic [XLEN-1:0] pc_plus4;

    // Redirect decode: only a real instruction in IF/ID may steer the PC;
    // jalr targets have bit 0 cleared, pc_src=3 behaves as sequential.
    always_comb begin
        redirect        = if_id_valid_q && ((pc_src == 2'd1) || (pc_src == 2'd2));
        redirect_target = (pc_src == 2'd2) ? {jalr_target[XLEN-1:1], 1'b0} : branch_target;
        pc_plus4        = pc_q + PC_STEP;
    end

    // Fetch FSM next-state and IF/ID/skid update; redirect beats stall.
    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        if_id_valid_d    = if_id_valid_q;
        if_id_instr_d    = if_id_instr_q;
        if_id_pc_d       = if_id_pc_q;
        if_id_pc_plus4_d = if_id_pc_plus4_q;
        skid_instr_d     = skid_instr_q;
        skid_pc_d        = skid_pc_q;

        unique case (state_q)
            ST_WAIT: begin
                if (redirect) begin
                    pc_d          = redirect_target;
                    if_id_valid_d = 1'b0;
                    state_d       = imem.imem_valid ? ST_WAIT : ST_DRAIN;
                end else if (imem.imem_valid) begin
                    pc_d = pc_plus4;
                    if (stall) begin
                        skid_instr_d = imem.imem_rdata;
                        skid_pc_d    = pc_q;
                        state_d      = ST_HELD;
                    end else begin
                        if_id_instr_d    = imem.imem_rdata;
                        if_id_pc_d       = pc_q;
                        if_id_pc_plus4_d = pc_plus4;
                        if_id_valid_d    = 1'b1;
                    end
                end else if (!stall) begin
                    if_id_valid_d = 1'b0;
                end
            end

            ST_DRAIN: begin
                if_id_valid_d = 1'b0;
                if (redirect) begin
                    pc_d = redirect_target;
                end
                if (imem.imem_valid) begin
                    state_d = ST_WAIT;
                end
            end

            ST_HELD: begin
                if (redirect) begin
                    pc_d          = redirect_target;
                    if_id_valid_d = 1'b0;
                    state_d       = ST_WAIT;
                end else if (!stall) begin
                    if_id_instr_d    = skid_instr_q;
                    if_id_pc_d       = skid_pc_q;
                    if_id_pc_plus4_d = skid_pc_q + PC_STEP;
                    if_id_valid_d    = 1'b1;
                    state_d          = ST_WAIT;
                end
            end

            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

    // State, PC, IF/ID and skid registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_WAIT;
            pc_q             <= PC_RESET;
            if_id_valid_q    <= 1'b0;
            if_id_instr_q    <= NOP_INSTR;
            if_id_pc_q       <= '0;
            if_id_pc_plus4_q <= PC_STEP;
            skid_instr_q     <= NOP_INSTR;
            skid_pc_q        <= '0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            if_id_valid_q    <= if_id_valid_d;
            if_id_instr_q    <= if_id_instr_d;
            if_id_pc_q       <= if_id_pc_d;
            if_id_pc_plus4_q <= if_id_pc_plus4_d;
            skid_instr_q     <= skid_instr_d;
            skid_pc_q        <= skid_pc_d;
        end
    end

    // Outputs: request only in WAIT and never during reset; an invalid
    // IF/ID always presents the NOP so control never decodes opcode 0.
    always_comb begin
        imem.imem_req  = rst_n && (state_q == ST_WAIT);
        imem.imem_addr = pc_q;
        if_id_valid    = if_id_valid_q;
        if_id_instr    = if_id_valid_q ? if_id_instr_q : NOP_INSTR;
        if_id_pc       = if_id_pc_q;
        if_id_pc_plus4 = if_id_pc_plus4_q;
        opcode         = if_id_instr[6:0];
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: a small instruction-memory model with
// programmable latency answers requests, and a linear sequence of steps
// checks IF/ID contents, PC and request behaviour against hand-computed values.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic [1:0]  pc_src;
    logic [31:0] branch_target;
    logic [31:0] jalr_target;
    logic        stall;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [6:0]  opcode;

    int tests_run;
    int tests_failed;
    int latency;

    logic        mem_pending;
    int          mem_count;
    logic [31:0] mem_addr;

    fetch_stage_if #(.XLEN(32)) imem ();

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_src         (pc_src),
        .branch_target  (branch_target),
        .jalr_target    (jalr_target),
        .stall          (stall),
        .imem           (imem.master),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .opcode         (opcode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: address 0 holds addi x1,x0,5; elsewhere a tagged address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0050_0093 : {8'hA5, a[23:0]};
    endfunction

    // Memory response: immediate when latency is 0, else after 'latency' cycles.
    always_comb begin
        imem.imem_valid = (!mem_pending && imem.imem_req && (latency == 0)) ||
                          (mem_pending && (mem_count >= latency));
        imem.imem_rdata = mem_pending ? mem_word(mem_addr) : mem_word(imem.imem_addr);
    end

    // Memory request tracking; reset together with the fetch stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_pending <= 1'b0;
            mem_count   <= 0;
            mem_addr    <= '0;
        end else if (imem.imem_valid) begin
            mem_pending <= 1'b0;
            mem_count   <= 0;
        end else if (mem_pending) begin
            mem_count <= mem_count + 1;
        end else if (imem.imem_req) begin
            mem_pending <= 1'b1;
            mem_count   <= 1;
            mem_addr    <= imem.imem_addr;
        end
    end

    // Drive inputs for one cycle, then advance to just after the rising edge.
    task automatic applyStimulus(input logic [1:0] src, input logic [31:0] bt,
                                 input logic [31:0] jt, input logic stl, input int lat);
        pc_src        = src;
        branch_target = bt;
        jalr_target   = jt;
        stall         = stl;
        latency       = lat;
        @(posedge clk);
        #1;
    endtask

    // Single comparison point.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Directed sequence.
    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        rst_n         = 1'b0;
        pc_src        = 2'd0;
        branch_target = '0;
        jalr_target   = '0;
        stall         = 1'b0;
        latency       = 0;

        // Reset values
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("rst_req", 32'(imem.imem_req), 32'h0);
        checkOutput("rst_addr", imem.imem_addr, 32'h0);
        checkOutput("rst_valid", 32'(if_id_valid), 32'h0);
        checkOutput("rst_instr", if_id_instr, 32'h0000_0013);
        checkOutput("rst_pc", if_id_pc, 32'h0);
        checkOutput("rst_pc4", if_id_pc_plus4, 32'h4);
        checkOutput("rst_opcode", 32'(opcode), 32'h13);
        rst_n = 1'b1;

        // Zero-latency fetch right after reset
        applyStimulus(2'd0, 32'h0, 32'h0, 1'b0, 0);
        checkOutput("z_valid", 32'(if_id_valid), 32'h1);
        checkOutput("z_instr", if_id_instr, 32'h0050_0093);
        checkOutput("z_pc", if_id_pc, 32'h0);
        checkOutput("z_pc4", if_id_pc_plus4, 32'h4);
        checkOutput("z_addr", imem.imem_addr, 32'h4);
        applyStimulus(2'd0, 32'h0, 32'h0, 1'b0, 0);
        checkOutput("z2_instr", if_id_instr, 32'hA500_0004);
        checkOutput("z2_addr", imem.imem_addr, 32'h8);

        // Two-cycle latency: address holds, IF/ID bubbles
        applyStimulus(2'd0, 32'h0, 32'h0, 1'b0, 2);
        checkOutput("l2a_valid", 32'(if_id_valid), 32'h0);
        checkOutput("l2a_addr", imem.imem_addr, 32'h8);
        checkOutput("l2a_req", 32'(imem.imem_req), 32'h1);
        applyStimulus(2'd0, 32'h0, 32'h0, 1'b0, 2);
        checkOutput("l2b_addr", imem.imem_addr, 32'h8);
        applyStimulus(2'd0, 32'h0, 32'h0, 1'b0, 2);
        checkOutput("l2c_valid", 32'(if_id_valid), 32'h1);
        checkOutput("l2c_instr", if_id_instr, 32'hA500_0008);
        checkOutput("l2c_pc", if_id_pc, 32'h8);
        checkOutput("l2c_addr", imem.imem_addr, 32'hC);

        // Branch from pc=8 to 0x40 while the 0xC fetch is in flight
        applyStimulus(2'd1, 32'h40, 32'h0, 1'b0, 2);
        checkOutput("br_addr", imem.imem_addr, 32'h40);
        checkOutput("br_req", 32'(imem.imem_req), 32'h0);
        checkOutput("br_valid", 32'(if_id_valid), 32'h0);
        checkOutput("br_opcode", 32'(opcode), 32'h13);
        applyStimulus(2'd0, 32'h0, 32'h0, 1'b0, 2);
        checkOutput("drain_req", 32'(imem.imem_req), 32'h0);
        applyStimulus(2'd0, 32'h0, 32'h0, 1'b0, 2);
        checkOutput("drained_req", 32'(imem.imem_req), 32'h1);
        checkOutput("drained_valid", 32'(if_id_valid), 32'h0);
        applyStimulus(2'd0, 32'h0, 32'h0, 1'b0, 0);
        checkOutput("br_instr", if_id_instr, 32'hA500_0040);
        checkOutput("br_pc", if_id_pc, 32'h40);
        checkOutput("br_next", imem.imem_addr, 32'h44);

        // jalr with odd target, response in the redirect cycle is discarded
        applyStimulus(2'd2, 32'h0, 32'h105, 1'b0, 0);
        checkOutput("jalr_addr", imem.imem_addr, 32'h104);
        checkOutput("jalr_req", 32'(imem.imem_req), 32'h1);
        checkOutput("jalr_valid", 32'(if_id_valid), 32'h0);
        applyStimulus(2'd0, 32'h0, 32'h0, 1'b0, 0);
        checkOutput("jalr_instr", if_id_instr, 32'hA500_0104);
        checkOutput("jalr_pc4", if_id_pc_plus4, 32'h108);

        // Stall for three cycles while the 0x108 response arrives
        applyStimulus(2'd0, 32'h0, 32'h0, 1'b1, 1);
        checkOutput("st1_valid", 32'(if_id_valid), 32'h1);
        checkOutput("st1_instr", if_id_instr, 32'hA500_0104);
        applyStimulus(2'd0, 32'h0, 32'h0, 1'b1, 1);
        checkOutput("st2_req", 32'(imem.imem_req), 32'h0);
        checkOutput("st2_addr", imem.imem_addr, 32'h10C);
        checkOutput("st2_instr", if_id_instr, 32'hA500_0104);
        applyStimulus(2'd0, 32'h0, 32'h0, 1'b1, 1);
        checkOutput("st3_req", 32'(imem.imem_req), 32'h0);
        checkOutput("st3_pc", if_id_pc, 32'h104);
        applyStimulus(2'd0, 32'h0, 32'h0, 1'b0, 1);
        checkOutput("unst_instr", if_id_instr, 32'hA500_0108);
        checkOutput("unst_pc", if_id_pc, 32'h108);
        checkOutput("unst_pc4", if_id_pc_plus4, 32'h10C);
        checkOutput("unst_req", 32'(imem.imem_req), 32'h1);

        // PC wrap at the top of the address space
        applyStimulus(2'd2, 32'h0, 32'hFFFF_FFFD, 1'b0, 1);
        checkOutput("wrap_tgt", imem.imem_addr, 32'hFFFF_FFFC);
        applyStimulus(2'd0, 32'h0, 32'h0, 1'b0, 0);
        checkOutput("wrap_req", 32'(imem.imem_req), 32'h1);
        applyStimulus(2'd0, 32'h0, 32'h0, 1'b0, 0);
        checkOutput("wrap_instr", if_id_instr, 32'hA5FF_FFFC);
        checkOutput("wrap_pc4", if_id_pc_plus4, 32'h0);
        checkOutput("wrap_addr", imem.imem_addr, 32'h0);

        // Reserved pc_src value acts as sequential
        applyStimulus(2'd3, 32'h300, 32'h400, 1'b0, 0);
        checkOutput("rsv_addr", imem.imem_addr, 32'h4);
        checkOutput("rsv_pc", if_id_pc, 32'h0);

        // Redirect with a 3-cycle fetch in flight, then reset mid-drain
        applyStimulus(2'd1, 32'h80, 32'h0, 1'b0, 3);
        checkOutput("d3_addr", imem.imem_addr, 32'h80);
        applyStimulus(2'd0, 32'h0, 32'h0, 1'b0, 3);
        checkOutput("d3_req", 32'(imem.imem_req), 32'h0);
        rst_n = 1'b0;
        #1;
        checkOutput("arst_addr", imem.imem_addr, 32'h0);
        checkOutput("arst_valid", 32'(if_id_valid), 32'h0);
        checkOutput("arst_opcode", 32'(opcode), 32'h13);
        checkOutput("arst_req", 32'(imem.imem_req), 32'h0);
        applyStimulus(2'd0, 32'h0, 32'h0, 1'b0, 0);
        rst_n = 1'b1;
        applyStimulus(2'd0, 32'h0, 32'h0, 1'b0, 0);
        checkOutput("post_instr", if_id_instr, 32'h0050_0093);
        checkOutput("post_valid", 32'(if_id_valid), 32'h1);
        checkOutput("post_addr", imem.imem_addr, 32'h4);

        // Redirect while HELD flushes the skid buffer
        applyStimulus(2'd0, 32'h0, 32'h0, 1'b1, 0);
        checkOutput("held_req", 32'(imem.imem_req), 32'h0);
        checkOutput("held_addr", imem.imem_addr, 32'h8);
        applyStimulus(2'd2, 32'h0, 32'h200, 1'b1, 0);
        checkOutput("hflush_valid", 32'(if_id_valid), 32'h0);
        checkOutput("hflush_addr", imem.imem_addr, 32'h200);
        applyStimulus(2'd0, 32'h0, 32'h0, 1'b0, 0);
        checkOutput("hflush_instr", if_id_instr, 32'hA500_0200);
        checkOutput("hflush_pc", if_id_pc, 32'h200);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
